// File: rtl/pipelined_fp_adder.sv
// Three-stage pipelined floating-point adder/subtractor with a valid/ready handshake.
// Define FP_ADDER_SPECIALS_EN to decode Inf/NaN; otherwise overflow saturates to max finite.
module pipelined_fp_adder #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] A,
  input  logic [EXP_W+MAN_W:0] B,
  input  logic                 Sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] Sum,
  output logic                 Cout
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;
  localparam int EW  = EXP_W + 2;
  localparam int LZW = $clog2(SW) + 1;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] EXP_MAXF = EXP_ONES - 1'b1;

  logic stall;
  logic adv;

  logic v1_q, v2_q, v3_q;

  logic             signA, signB;
  logic [EXP_W-1:0] expA, expB, expS, expDiff;
  logic [MAN_W-1:0] fracA, fracB;
  logic             zeroA, zeroB;
  logic [W-2:0]     magA, magB;
  logic [SW-1:0]    sigA, sigB, sigS;
  logic [2*SW-1:0]  shiftExt;

  logic             s1SignL_d, s1SignL_q;
  logic             s1SignS_d, s1SignS_q;
  logic [EXP_W-1:0] s1Exp_d, s1Exp_q;
  logic [SW-1:0]    s1SigL_d, s1SigL_q;
  logic [SW-1:0]    s1SigS_d, s1SigS_q;
  logic             s1Spec_d, s1Spec_q;
  logic [W-1:0]     s1SpecVal_d, s1SpecVal_q;

  logic             effSub;
  logic [SW:0]      s2Sum_d, s2Sum_q;
  logic             s2Sign_q;
  logic             s2ZeroSign_q;
  logic [EXP_W-1:0] s2Exp_q;
  logic             s2Spec_q;
  logic [W-1:0]     s2SpecVal_q;

  logic [LZW-1:0]   lz;
  logic [SW-1:0]    norm;
  logic [EW-1:0]    expN, expR;
  logic             roundUp;
  logic [MAN_W+1:0] mantR;
  logic [MAN_W-1:0] fracR;
  logic [W-1:0]     s3Sum_d, s3Sum_q;
  logic             s3Cout_d, s3Cout_q;

  // A stalled output freezes the whole pipe, bubbles included.
  assign out_valid = v3_q;
  assign stall     = v3_q && !out_ready;
  assign adv       = !stall;
  assign in_ready  = adv;
  assign Sum       = s3Sum_q;
  assign Cout      = s3Cout_q;

`ifdef FP_ADDER_SPECIALS_EN
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  logic infA, infB, nanA, nanB;
  assign infA = (expA == EXP_ONES) && (fracA == '0);
  assign infB = (expB == EXP_ONES) && (fracB == '0);
  assign nanA = (expA == EXP_ONES) && (fracA != '0);
  assign nanB = (expB == EXP_ONES) && (fracB != '0);
`endif

  // Stage 1: unpack, order by magnitude, align the smaller significand with guard/round/sticky.
  always_comb begin
    signA = A[W-1];
    signB = B[W-1] ^ Sub;
    expA  = A[W-2:MAN_W];
    expB  = B[W-2:MAN_W];
    fracA = A[MAN_W-1:0];
    fracB = B[MAN_W-1:0];
    zeroA = (expA == '0);
    zeroB = (expB == '0);
    magA  = zeroA ? '0 : A[W-2:0];
    magB  = zeroB ? '0 : B[W-2:0];
    sigA  = zeroA ? '0 : {1'b1, fracA, 3'b000};
    sigB  = zeroB ? '0 : {1'b1, fracB, 3'b000};

    if (magA >= magB) begin
      s1SignL_d = signA;
      s1SignS_d = signB;
      s1Exp_d   = expA;
      s1SigL_d  = sigA;
      expS      = expB;
      sigS      = sigB;
    end else begin
      s1SignL_d = signB;
      s1SignS_d = signA;
      s1Exp_d   = expB;
      s1SigL_d  = sigB;
      expS      = expA;
      sigS      = sigA;
    end

    expDiff  = s1Exp_d - expS;
    shiftExt = {sigS, {SW{1'b0}}} >> expDiff;
    if (int'(expDiff) >= SW - 1)
      s1SigS_d = {{(SW-1){1'b0}}, |sigS};
    else
      s1SigS_d = shiftExt[2*SW-1:SW] | {{(SW-1){1'b0}}, |shiftExt[SW-1:0]};

    s1Spec_d    = 1'b0;
    s1SpecVal_d = '0;
`ifdef FP_ADDER_SPECIALS_EN
    if (nanA || nanB || (infA && infB && (signA != signB))) begin
      s1Spec_d    = 1'b1;
      s1SpecVal_d = QNAN;
    end else if (infA) begin
      s1Spec_d    = 1'b1;
      s1SpecVal_d = {signA, EXP_ONES, {MAN_W{1'b0}}};
    end else if (infB) begin
      s1Spec_d    = 1'b1;
      s1SpecVal_d = {signB, EXP_ONES, {MAN_W{1'b0}}};
    end
`endif
  end

  // Stage 2: the larger significand minus or plus the aligned smaller one never goes negative.
  assign effSub  = s1SignL_q ^ s1SignS_q;
  assign s2Sum_d = effSub ? ({1'b0, s1SigL_q} - {1'b0, s1SigS_q})
                          : ({1'b0, s1SigL_q} + {1'b0, s1SigS_q});

  // Stage 3: normalise, round to nearest even, then classify zero/underflow/overflow.
  always_comb begin
    lz = '0;
    for (int i = 0; i < SW; i++)
      if (s2Sum_q[i]) lz = LZW'(SW - 1 - i);

    if (s2Sum_q[SW]) begin
      norm = {s2Sum_q[SW:2], s2Sum_q[1] | s2Sum_q[0]};
      expN = {2'b00, s2Exp_q} + EW'(1);
    end else begin
      norm = s2Sum_q[SW-1:0] << lz;
      expN = {2'b00, s2Exp_q} - EW'(lz);
    end

    roundUp = norm[2] & (norm[1] | norm[0] | norm[3]);
    mantR   = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(roundUp);
    if (mantR[MAN_W+1]) begin
      fracR = mantR[MAN_W:1];
      expR  = expN + EW'(1);
    end else begin
      fracR = mantR[MAN_W-1:0];
      expR  = expN;
    end

    s3Cout_d = 1'b0;
    if (s2Spec_q) begin
      s3Sum_d = s2SpecVal_q;
    end else if (s2Sum_q == '0) begin
      s3Sum_d = {s2ZeroSign_q, {(W-1){1'b0}}};
    end else if (expR[EW-1] || (expR == '0)) begin
      s3Sum_d = {s2Sign_q, {(W-1){1'b0}}};
    end else if (expR >= {2'b00, EXP_ONES}) begin
      s3Cout_d = 1'b1;
`ifdef FP_ADDER_SPECIALS_EN
      s3Sum_d  = {s2Sign_q, EXP_ONES, {MAN_W{1'b0}}};
`else
      s3Sum_d  = {s2Sign_q, EXP_MAXF, {MAN_W{1'b1}}};
`endif
    end else begin
      s3Sum_d = {s2Sign_q, expR[EXP_W-1:0], fracR};
    end
  end

  // Valid bits and output registers are the only reset state.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      s3Sum_q  <= '0;
      s3Cout_q <= 1'b0;
    end else if (adv) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (v2_q) begin
        s3Sum_q  <= s3Sum_d;
        s3Cout_q <= s3Cout_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1SignL_q    <= s1SignL_d;
      s1SignS_q    <= s1SignS_d;
      s1Exp_q      <= s1Exp_d;
      s1SigL_q     <= s1SigL_d;
      s1SigS_q     <= s1SigS_d;
      s1Spec_q     <= s1Spec_d;
      s1SpecVal_q  <= s1SpecVal_d;
      s2Sum_q      <= s2Sum_d;
      s2Sign_q     <= s1SignL_q;
      s2ZeroSign_q <= s1SignL_q & s1SignS_q;
      s2Exp_q      <= s1Exp_q;
      s2Spec_q     <= s1Spec_q;
      s2SpecVal_q  <= s1SpecVal_q;
    end
  end

endmodule

// File: tb/tb_pipelined_fp_adder.sv
// Directed bench for pipelined_fp_adder in single-precision format.
// Expected sums are hand-computed; FP_ADDER_SPECIALS_EN selects the special-value expectations.
module tb_pipelined_fp_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Sum;
  logic        Cout;

  int checkCount = 0;
  int errCount   = 0;

  always #5 clk = ~clk;

  pipelined_fp_adder #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Sub       (Sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Present one operation for a single cycle; it must be accepted.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub);
    A        = a;
    B        = b;
    Sub      = sub;
    in_valid = 1'b1;
    #3;
    checkOutput("accept.inReady", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [31:0] expSum, input logic [31:0] sumMask,
                       input logic expCout);
    int lat;
    applyStimulus(a, b, sub);
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'd3);
    checkOutput({tag, ".sum"}, Sum & sumMask, expSum);
    checkOutput({tag, ".cout"}, {31'b0, Cout}, {31'b0, expCout});
    @(posedge clk);
    #1;
    checkOutput({tag, ".drained"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    Sub       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.outValid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset.sum", Sum, 32'h0000_0000);
    checkOutput("reset.cout", {31'b0, Cout}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("reset.inReady", {31'b0, in_ready}, 32'd1);

    runOp("cancelToZero",   32'hC093_3333, 32'h4093_3333, 1'b0, 32'h0000_0000, '1, 1'b0);
    runOp("onePlusOne",     32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, '1, 1'b0);
    runOp("oneMinusOne",    32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, '1, 1'b0);
    runOp("negZeroPlusNeg", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, '1, 1'b0);
    runOp("negZeroMinusPos",32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, '1, 1'b0);
    runOp("posZeroPlusNeg", 32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, '1, 1'b0);
    runOp("farShiftSticky", 32'h3F80_0000, 32'h3080_0000, 1'b0, 32'h3F80_0000, '1, 1'b0);
    runOp("subnormalIsZero",32'h3F80_0000, 32'h0000_0001, 1'b0, 32'h3F80_0000, '1, 1'b0);
    runOp("subnormalPair",  32'h0040_0000, 32'h8040_0000, 1'b0, 32'h0000_0000, '1, 1'b0);
    runOp("underflowFlush", 32'h0080_0000, 32'h00C0_0000, 1'b1, 32'h8000_0000, '1, 1'b0);
    runOp("tieStaysEven",   32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, '1, 1'b0);
    runOp("tieRoundsUp",    32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, '1, 1'b0);
    runOp("roundCarry",     32'h3FFF_FFFF, 32'h3380_0000, 1'b0, 32'h4000_0000, '1, 1'b0);
    runOp("cancelShift",    32'h3FC0_0000, 32'h3FA0_0000, 1'b1, 32'h3E80_0000, '1, 1'b0);
    runOp("negResult",      32'h4040_0000, 32'h40A0_0000, 1'b1, 32'hC000_0000, '1, 1'b0);
`ifdef FP_ADDER_SPECIALS_EN
    runOp("overflowInf",    32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, '1, 1'b1);
    runOp("infMinusInf",    32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 32'h7FC0_0000, 1'b0);
    runOp("nanIn",          32'h7FA0_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 32'h7FC0_0000, 1'b0);
    runOp("finiteMinusInf", 32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, '1, 1'b0);
`else
    runOp("overflowSat",    32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F7F_FFFF, '1, 1'b1);
    runOp("onesExpOrdinary",32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F7F_FFFF, '1, 1'b1);
`endif

    // Back-to-back issue must produce results on consecutive cycles.
    A = 32'h41CC_CCCD; B = 32'hC189_999A; Sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    A = 32'h41CC_CCCD; B = 32'h4189_999A;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("b2b.first.valid", {31'b0, out_valid}, 32'd1);
    checkOutput("b2b.first.sum", Sum, 32'h4106_6666);
    @(posedge clk);
    #1;
    checkOutput("b2b.second.valid", {31'b0, out_valid}, 32'd1);
    checkOutput("b2b.second.sum", Sum, 32'h422B_3334);
    @(posedge clk);
    #1;
    checkOutput("b2b.drained", {31'b0, out_valid}, 32'd0);

    // Held result under backpressure, then exactly one transfer.
    out_ready = 1'b0;
    applyStimulus(32'h41CC_CCCD, 32'h4189_999A, 1'b1);
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("stall.latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall.inReady", {31'b0, in_ready}, 32'd0);
      checkOutput("stall.valid", {31'b0, out_valid}, 32'd1);
      checkOutput("stall.sum", Sum, 32'h4106_6666);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    checkOutput("stall.release.inReady", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("stall.single.first", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("stall.single.second", {31'b0, out_valid}, 32'd0);

    // Reset while two operations are in flight discards both.
    A = 32'h3F80_0000; B = 32'h3F80_0000; Sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    A = 32'h4040_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("midReset.valid", {31'b0, out_valid}, 32'd0);
      checkOutput("midReset.sum", Sum, 32'h0000_0000);
      checkOutput("midReset.inReady", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
    end
    runOp("afterReset", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, '1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, errCount);
    $finish;
  end

endmodule

// File: doc/pipelined_fp_adder.md
PIPELINED_FP_ADDER -- requirements
Module: pipelined_fp_adder

Interface
REQ-001 Parameter EXP_W, default 8, SHALL set the exponent field width (bias = 2^(EXP_W-1)-1).
REQ-002 Parameter MAN_W, default 23, SHALL set the stored fraction width; operand width W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 in_valid  input  1  SHALL qualify A, B and Sub.
REQ-006 in_ready  output  1  SHALL indicate the operation is accepted this cycle.
REQ-007 A  input  W  SHALL carry operand A (sign|exp|frac).
REQ-008 B  input  W  SHALL carry operand B.
REQ-009 Sub  input  1  SHALL select A-B when 1 and A+B when 0.
REQ-010 out_valid  output  1  SHALL qualify Sum and Cout.
REQ-011 out_ready  input  1  SHALL indicate the consumer takes the result this cycle.
REQ-012 Sum  output  W  SHALL carry the rounded result.
REQ-013 Cout  output  1  SHALL flag exponent overflow of the result.

Function
REQ-014 Transfer SHALL occur on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-015 Pipeline SHALL have 3 registered stages: S1 unpack/compare/align, S2 significand add/sub, S3 normalise/round/pack.
REQ-016 Latency SHALL be exactly 3 cycles from acceptance to out_valid with no stall.
REQ-017 stall = out_valid && !out_ready; in_ready SHALL equal !stall; on stall every stage register and valid bit SHALL hold.
REQ-018 Throughput SHALL be one op per cycle when out_ready stays high; empty stage slots (bubbles) SHALL advance regardless of downstream state only when not stalled.
REQ-019 S1 SHALL invert B's sign when Sub=1, swap so the larger magnitude is first, and right-shift the smaller significand by the exponent difference keeping guard, round and sticky bits; shift >= MAN_W+3 SHALL leave only sticky.
REQ-020 S2 SHALL add significands on equal effective signs, otherwise subtract smaller from larger; result sign = larger operand's sign.
REQ-021 S3 SHALL normalise (1-bit right shift on carry, leading-zero left shift on cancellation), then round to nearest, ties to even, renormalising on rounding carry.
REQ-022 Exact zero result SHALL be +0, except (-0)+(-0) and (-0)-(+0) giving -0.
REQ-023 Subnormal inputs SHALL be treated as signed zero; a result exponent underflowing to <=0 SHALL flush to signed zero with Cout=0.
REQ-024 Result exponent >= 2^EXP_W-1 SHALL set Cout=1 for that result; Sum per REQ-031/REQ-032.
REQ-025 Sum and Cout SHALL be registered outputs held stable while out_valid&&!out_ready.

Reset
REQ-026 rst=1 SHALL clear all stage valid bits at the next edge, so out_valid=0 the following cycle.
REQ-027 rst SHALL force Sum=0 and Cout=0; datapath registers other than outputs need no reset.
REQ-028 rst SHALL dominate in_valid and out_ready in the same cycle; in-flight ops are discarded, none emitted after release.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-030 Macro FP_ADDER_SPECIALS_EN SHALL control IEEE special-value handling.
REQ-031 Defined: exponent all-ones inputs decode as Inf/NaN; NaN in -> quiet NaN (frac MSB set) out; +Inf+(-Inf) -> quiet NaN; Inf op finite -> that Inf; overflow -> signed Inf with Cout=1.
REQ-032 Undefined: no special decoding (all-ones exponent treated as ordinary); overflow SHALL saturate Sum to signed max finite (exp 2^EXP_W-2, frac all ones) with Cout=1.

Verification (default parameters)
REQ-033 A=0xC0933333 (-4.6), B=0x40933333, Sub=0 -> Sum=0x00000000, Cout=0, out_valid exactly 3 cycles after acceptance.
REQ-034 Back-to-back ops 0x41CCCCCD+0xC189999A then 0x41CCCCCD+0x4189999A, out_ready=1 -> consecutive cycles 0x41066666 then 0x422B3334.
REQ-035 0x41CCCCCD with Sub=1, B=0x4189999A, out_ready=0 for 5 cycles after out_valid -> in_ready=0, Sum=0x41066666 held, single transfer when out_ready rises.
REQ-036 0x7F7FFFFF+0x7F7FFFFF -> with macro Sum=0x7F800000 Cout=1; without Sum=0x7F7FFFFF Cout=1.
REQ-037 Accept 2 ops, assert rst 1 cycle at cycle 2 -> no out_valid afterwards, Sum=0, in_ready=1 after release.
REQ-038 With macro: 0x7F800000+0xFF800000 -> quiet NaN (exp all ones, frac MSB 1), Cout=0.
